sobel_stream: RTL and testbench

Parametrised raster-scan Sobel edge detector for the image pipeline. It accepts one pixel per cycle from the frame source (SDRAM reader or bench ROM) with gaps allowed. It buffers two lines internally, forms a 3x3 window and emits one gradient pixel per input pixel, in raster order, with the border forced to zero. It generalises the fixed 8-bit / 640x480 Sobel stage with configurable width and frame size, a binary threshold mode, input gaps, frame markers and self-flushing at end of frame.

---
 rtl/sobel_stream.sv | 198 +++++++++++++++++++
 tb/tb_sobel_stream.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream.sv
// sobel_stream: raster-scan 3x3 Sobel edge detector, one output per input slot.
//   clk_i/rst_i   : clock, synchronous active-high reset
//   sof_i/valid_i/data_i : input pixel stream, sof_i marks pixel (0,0)
//   ready_o       : low while the block flushes the end of a frame
//   threshold_i   : compare level for binary output mode
//   valid_o/data_o/sof_o/eof_o : output gradient stream (border forced to 0)
//   err_o         : one-cycle pulse when a frame is aborted by an early sof_i
module sobel_stream #(
  parameter int DATA_W   = 8,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int OUT_MODE = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sof_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  input  logic [DATA_W+2:0] threshold_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              sof_o,
  output logic              eof_o,
  output logic              err_o
);
  localparam int GW = DATA_W + 3;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 2);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FLEND = RW'(IMG_H + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d, slot_col;
  logic [RW-1:0]     row_q, row_d, slot_row;
  logic              slot;
  logic [DATA_W-1:0] slot_pix;
  logic              err_q, err_d;

  logic [DATA_W-1:0] lb0_q [IMG_W];  // row above the slot row
  logic [DATA_W-1:0] lb1_q [IMG_W];  // two rows above the slot row
  logic [DATA_W-1:0] rd0, rd1;
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];

  logic [CW-1:0] ctr_col;
  logic [RW-1:0] ctr_row;
  logic          v1_q, v1_d, sof1_q, sof1_d, eof1_q, eof1_d, bord1_q, bord1_d;

  logic [GW-1:0]     gx, gy, abs_gx, abs_gy, mag;
  logic              valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Slot sequencing: every accepted pixel and every flush cycle is one slot.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    slot     = 1'b0;
    slot_col = col_q;
    slot_row = row_q;
    slot_pix = data_i;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (valid_i && sof_i) begin
          slot     = 1'b1;
          slot_col = '0;
          slot_row = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (valid_i) begin
          slot = 1'b1;
          if (sof_i) begin
            slot_col = '0;
            slot_row = '0;
            err_d    = (col_q != '0) || (row_q != '0);
          end else if (col_q == COL_LAST && row_q == ROW_LAST) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        slot     = 1'b1;
        slot_pix = '0;
        // The last flush slot is (0, IMG_H+1): its window centre is the final pixel.
        if (row_q == ROW_FLEND) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (slot) begin
      if (slot_col == COL_LAST) begin
        col_d = '0;
        row_d = slot_row + RW'(1);
      end else begin
        col_d = slot_col + CW'(1);
        row_d = slot_row;
      end
    end
  end

  // Window shift and centre position; the window centre lags the slot by IMG_W+1.
  always_comb begin
    rd0   = lb0_q[slot_col];
    rd1   = lb1_q[slot_col];
    win_d = win_q;
    if (slot) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = rd1;
      win_d[1][2] = rd0;
      win_d[2][2] = slot_pix;
    end
    if (slot_col == '0) begin
      ctr_col = COL_LAST;
      ctr_row = slot_row - RW'(2);
    end else begin
      ctr_col = slot_col - CW'(1);
      ctr_row = slot_row - RW'(1);
    end
    v1_d    = slot && ((slot_row >= RW'(2)) || (slot_row == RW'(1) && slot_col != '0));
    sof1_d  = v1_d && ctr_col == '0 && ctr_row == '0;
    eof1_d  = v1_d && ctr_col == COL_LAST && ctr_row == ROW_LAST;
    bord1_d = (ctr_col == '0) || (ctr_col == COL_LAST) || (ctr_row == '0) || (ctr_row == ROW_LAST);
  end

  // Gradient, magnitude and output formatting.
  always_comb begin
    gx = (GW'(win_q[0][2]) + (GW'(win_q[1][2]) << 1) + GW'(win_q[2][2]))
       - (GW'(win_q[0][0]) + (GW'(win_q[1][0]) << 1) + GW'(win_q[2][0]));
    gy = (GW'(win_q[2][0]) + (GW'(win_q[2][1]) << 1) + GW'(win_q[2][2]))
       - (GW'(win_q[0][0]) + (GW'(win_q[0][1]) << 1) + GW'(win_q[0][2]));
    abs_gx  = gx[GW-1] ? (~gx + GW'(1)) : gx;
    abs_gy  = gy[GW-1] ? (~gy + GW'(1)) : gy;
    mag     = abs_gx + abs_gy;
    data_d  = '0;
    if (v1_q && !bord1_q) begin
      if (OUT_MODE == 1) data_d = (mag >= threshold_i) ? '1 : '0;
      else               data_d = (|mag[GW-1:DATA_W]) ? '1 : mag[DATA_W-1:0];
    end
    valid_d = v1_q;
    sof_d   = sof1_q;
    eof_d   = eof1_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
      v1_q    <= 1'b0;
      sof1_q  <= 1'b0;
      eof1_q  <= 1'b0;
      bord1_q <= 1'b0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
      v1_q    <= v1_d;
      sof1_q  <= sof1_d;
      eof1_q  <= eof1_d;
      bord1_q <= bord1_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      data_q  <= data_d;
    end
  end

  // Line buffers and window carry no reset: stale rows only feed border outputs.
  always_ff @(posedge clk_i) begin
    win_q <= win_d;
    if (slot) begin
      lb1_q[slot_col] <= rd0;
      lb0_q[slot_col] <= slot_pix;
    end
  end

  assign ready_o = (state_q != S_FLUSH);
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sof_o   = sof_q;
  assign eof_o   = eof_q;
  assign err_o   = err_q;
endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: self-checking bench for sobel_stream, one instance per
// output mode sharing the same input stream, compared against a software Sobel.
module tb_sobel_stream;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, sof, valid;
  logic [DW-1:0] data;
  logic [DW+2:0] thr;
  logic          rdy0, vo0, so0, eo0, er0;
  logic          rdy1, vo1, so1, eo1, er1;
  logic [DW-1:0] do0, do1;

  sobel_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .OUT_MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .sof_i(sof), .valid_i(valid), .data_i(data),
    .ready_o(rdy0), .threshold_i(thr), .valid_o(vo0), .data_o(do0),
    .sof_o(so0), .eof_o(eo0), .err_o(er0));

  sobel_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .OUT_MODE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .sof_i(sof), .valid_i(valid), .data_i(data),
    .ready_o(rdy1), .threshold_i(thr), .valid_o(vo1), .data_o(do1),
    .sof_o(so1), .eof_o(eo1), .err_o(er1));

  int checks = 0;
  int errors = 0;
  int q0[$];
  int q1[$];
  int err_cnt = 0;
  int rdy_low = 0;

  // Output record: eof<<9 | sof<<8 | data
  always @(negedge clk) begin
    if (vo0) q0.push_back((int'(eo0) << 9) | (int'(so0) << 8) | int'(do0));
    if (vo1) q1.push_back((int'(eo1) << 9) | (int'(so1) << 8) | int'(do1));
    if (er0) err_cnt++;
    if (!rdy0) rdy_low++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int px(input int im[N], input int r, input int c);
    return im[r * W + c];
  endfunction

  // Software Sobel on a stored frame.
  function automatic int ref_out(input int im[N], input int n, input int mode, input int th);
    int r, c, gx, gy, mag;
    r = n / W;
    c = n % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    gx = (px(im, r-1, c+1) + 2*px(im, r, c+1) + px(im, r+1, c+1))
       - (px(im, r-1, c-1) + 2*px(im, r, c-1) + px(im, r+1, c-1));
    gy = (px(im, r+1, c-1) + 2*px(im, r+1, c) + px(im, r+1, c+1))
       - (px(im, r-1, c-1) + 2*px(im, r-1, c) + px(im, r-1, c+1));
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mode == 1) return (mag >= th) ? 255 : 0;
    return (mag > 255) ? 255 : mag;
  endfunction

  task automatic clear_mon();
    q0.delete();
    q1.delete();
    err_cnt = 0;
    rdy_low = 0;
  endtask

  // Drive pixels [from,to) of im; gap_pct = chance of an idle cycle before each.
  task automatic send_pixels(input int im[N], input int from, input int to,
                             input int gap_pct, input bit first_sof);
    for (int i = from; i < to; i++) begin
      for (int g = 0; g < 6 && $urandom_range(99) < gap_pct; g++) begin
        valid = 1'b0;
        sof   = 1'b0;
        @(posedge clk); #1;
      end
      valid = 1'b1;
      sof   = (i == from) && first_sof;
      data  = DW'(im[i]);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    sof   = 1'b0;
  endtask

  task automatic wait_out(input int cnt, input string tag);
    int k = 0;
    while ((q0.size() < cnt || q1.size() < cnt) && k < 600) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_count_m0"}, q0.size(), cnt);
    chk({tag, "_count_m1"}, q1.size(), cnt);
  endtask

  // Compare outputs n0..n1-1 of a frame, stored from queue index qoff.
  task automatic check_q(input int im[N], input int qoff, input int n0, input int n1,
                         input int th, input string tag);
    int exp, act, idx;
    for (int n = n0; n < n1; n++) begin
      idx = qoff + n - n0;
      for (int m = 0; m < 2; m++) begin
        exp = ((n == N - 1) ? 512 : 0) | ((n == 0) ? 256 : 0) | ref_out(im, n, m, th);
        if (m == 0) act = (idx < q0.size()) ? q0[idx] : -1;
        else        act = (idx < q1.size()) ? q1[idx] : -1;
        chk($sformatf("%s_m%0d_px%0d", tag, m, n), act, exp);
      end
    end
  endtask

  function automatic int count_ff(input int which);
    int cnt = 0;
    if (which == 0) begin
      foreach (q0[i]) if ((q0[i] & 255) == 255) cnt++;
    end else begin
      foreach (q1[i]) if ((q1[i] & 255) == 255) cnt++;
    end
    return cnt;
  endfunction

  function automatic void make_img(input int pat, output int im[N]);
    for (int i = 0; i < N; i++) begin
      case (pat)
        0:       im[i] = 8'h80;
        1:       im[i] = ((i % W) >= 4) ? 8'hFF : 8'h00;
        default: im[i] = int'($urandom_range(255));
      endcase
    end
  endfunction

  // pattern: 0 flat 0x80, 1 vertical step, 2 random; exp_ff* < 0 means not tabulated
  typedef struct {
    int pat;
    int th;
    int gap;
    int exp_ff0;
    int exp_ff1;
  } vec_t;

  vec_t tbl[6];
  int   img[N];
  int   img2[N];

  initial begin
    tbl[0] = '{pat: 0, th: 1020, gap: 0,  exp_ff0: 0,  exp_ff1: 0};
    tbl[1] = '{pat: 1, th: 1020, gap: 0,  exp_ff0: 8,  exp_ff1: 8};
    tbl[2] = '{pat: 1, th: 1021, gap: 0,  exp_ff0: 8,  exp_ff1: 0};
    tbl[3] = '{pat: 0, th: 0,    gap: 0,  exp_ff0: 0,  exp_ff1: 24};
    tbl[4] = '{pat: 2, th: 300,  gap: 50, exp_ff0: -1, exp_ff1: -1};
    tbl[5] = '{pat: 2, th: 150,  gap: 50, exp_ff0: -1, exp_ff1: -1};

    rst = 1'b1; valid = 1'b0; sof = 1'b0; data = '0; thr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(vo0) + int'(vo1), 0);
    chk("rst_data",  int'(do0) + int'(do1), 0);
    chk("rst_sof_eof", int'(so0) + int'(eo0) + int'(so1) + int'(eo1), 0);
    chk("rst_err",   int'(er0) + int'(er1), 0);
    chk("rst_ready", int'(rdy0) + int'(rdy1), 2);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
      make_img(tbl[t].pat, img);
      thr = (DW+3)'(tbl[t].th);
      clear_mon();
      send_pixels(img, 0, N, tbl[t].gap, 1'b1);
      wait_out(N, $sformatf("t%0d", t));
      check_q(img, 0, 0, N, tbl[t].th, $sformatf("t%0d", t));
      chk($sformatf("t%0d_ready_low", t), rdy_low, W + 1);
      chk($sformatf("t%0d_err", t), err_cnt, 0);
      if (tbl[t].exp_ff0 >= 0) chk($sformatf("t%0d_ff_m0", t), count_ff(0), tbl[t].exp_ff0);
      if (tbl[t].exp_ff1 >= 0) chk($sformatf("t%0d_ff_m1", t), count_ff(1), tbl[t].exp_ff1);
    end

    // Premature sof at pixel (5,2): 21 pixels of frame A, then frame B restarts.
    make_img(2, img);
    make_img(2, img2);
    thr = 11'd250;
    clear_mon();
    send_pixels(img, 0, 21, 0, 1'b1);
    valid = 1'b1; sof = 1'b1; data = DW'(img2[0]);
    @(posedge clk); #1;
    chk("abort_err_pulse", int'(er0) + int'(er1), 2);
    send_pixels(img2, 1, N, 0, 1'b0);
    wait_out(12 + N, "abort");
    chk("abort_err_count", err_cnt, 1);
    check_q(img, 0, 0, 12, 250, "abort_old");
    check_q(img2, 12, 0, N, 250, "abort_new");

    // Reset in place of pixel (3,3), then a fresh frame.
    make_img(2, img);
    send_pixels(img, 0, 27, 25, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_outputs", int'(vo0) + int'(so0) + int'(eo0) + int'(er0) + int'(do0)
                      + int'(vo1) + int'(so1) + int'(eo1) + int'(er1) + int'(do1), 0);
    chk("mrst_ready", int'(rdy0) + int'(rdy1), 2);
    rst = 1'b0;
    clear_mon();
    make_img(2, img);
    thr = 11'd400;
    send_pixels(img, 0, N, 30, 1'b1);
    wait_out(N, "mrst");
    check_q(img, 0, 0, N, 400, "mrst");
    chk("mrst_err", err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
